// File: rtl/video_pkg.sv
// Shared constants, control codes and controller state encoding for the
// text-mode VRAM path.
package video_pkg;

  localparam int COLS   = 60;
  localparam int ROWS   = 34;
  localparam int ADDR_W = 11;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CLR_ROW = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= 8'h20) && (ch <= 8'h7E);
  endfunction

endpackage

// File: rtl/vram_cursor.sv
// Cursor column/row plus line base register; the cell address is base + col,
// so no multiplier is needed.
module vram_cursor
  import video_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              home_i,
  input  logic              nl_i,
  input  logic              cr_i,
  input  logic              back_i,
  input  logic              step_i,
  output logic [5:0]        col_o,
  output logic [5:0]        row_o,
  output logic [ADDR_W-1:0] base_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_col_o
);

  logic [5:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // Cursor next-state: home > new line > carriage return > back > step.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (home_i) begin
      col_d  = 6'd0;
      row_d  = 6'd0;
      base_d = '0;
    end else if (nl_i) begin
      col_d = 6'd0;
      if (row_q == 6'(ROWS - 1)) begin
        row_d  = 6'd0;
        base_d = '0;
      end else begin
        row_d  = row_q + 6'd1;
        base_d = base_q + ADDR_W'(COLS);
      end
    end else if (cr_i) begin
      col_d = 6'd0;
    end else if (back_i && (col_q != 6'd0)) begin
      col_d = col_q - 6'd1;
    end else if (step_i && (col_q != 6'(COLS - 1))) begin
      col_d = col_q + 6'd1;
    end else begin
      col_d = col_q;
    end
  end

  // Cursor state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q  <= 6'd0;
      row_q  <= 6'd0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign base_o     = base_q;
  assign addr_o     = base_q + ADDR_W'(col_q);
  assign last_col_o = (col_q == 6'(COLS - 1));

endmodule

// File: rtl/vram_console.sv
// Text-console write controller: turns a character stream into single-port
// VRAM cell writes, handling control codes, wrap, row clear and full clear.
module vram_console
  import video_pkg::*;
#(
  parameter logic [7:0] RST_ATTR = 8'h0F
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              char_valid_i,
  input  logic [7:0]        char_data_i,
  input  logic [7:0]        attr_i,
  output logic              char_ready_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_ad_o,
  output logic [15:0]       vram_din_o,
  output logic [5:0]        cursor_col_o,
  output logic [5:0]        cursor_row_o
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        attr_q, attr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [15:0]       din_q, din_d;
  logic              busy_q, busy_d;
  logic              clr_wr_d;
  logic              accept_s;

  logic              home_s, nl_s, cr_s, back_s, step_s;
  logic [ADDR_W-1:0] base_s, cur_addr_s;
  logic              last_col_s;

  vram_cursor u_cursor (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .home_i     (home_s),
    .nl_i       (nl_s),
    .cr_i       (cr_s),
    .back_i     (back_s),
    .step_i     (step_s),
    .col_o      (cursor_col_o),
    .row_o      (cursor_row_o),
    .base_o     (base_s),
    .addr_o     (cur_addr_s),
    .last_col_o (last_col_s)
  );

  // busy_q also covers the trailing clear write, so ready never overlaps it.
  assign char_ready_o = (state_q == ST_IDLE) && !busy_q && !clear_i;
  assign accept_s     = char_valid_i && char_ready_o;

  // FSM next state, write-port mux and cursor commands.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    attr_d   = attr_q;
    we_d     = 1'b0;
    ad_d     = ad_q;
    din_d    = din_q;
    clr_wr_d = 1'b0;
    home_s   = 1'b0;
    nl_s     = 1'b0;
    cr_s     = 1'b0;
    back_s   = 1'b0;
    step_s   = 1'b0;
    if (clear_i || (accept_s && (char_data_i == CH_FF))) begin
      attr_d   = attr_i;
      we_d     = 1'b1;
      ad_d     = '0;
      din_d    = {attr_i, CH_SPACE};
      cnt_d    = ADDR_W'(1);
      clr_wr_d = 1'b1;
      state_d  = ST_CLR_ALL;
    end else begin
      case (state_q)
        ST_CLR_ALL: begin
          we_d     = 1'b1;
          ad_d     = cnt_q;
          din_d    = {attr_q, CH_SPACE};
          clr_wr_d = 1'b1;
          if (cnt_q == LAST_CELL) begin
            home_s  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        ST_CLR_ROW: begin
          we_d     = 1'b1;
          ad_d     = base_s + cnt_q;
          din_d    = {attr_q, CH_SPACE};
          clr_wr_d = 1'b1;
          if (cnt_q == LAST_COL) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            attr_d = attr_i;
            if (is_printable(char_data_i)) begin
              we_d  = 1'b1;
              ad_d  = cur_addr_s;
              din_d = {attr_i, char_data_i};
              if (last_col_s) begin
                nl_s    = 1'b1;
                cnt_d   = '0;
                state_d = ST_CLR_ROW;
              end else begin
                step_s = 1'b1;
              end
            end else if (char_data_i == CH_LF) begin
              nl_s    = 1'b1;
              cnt_d   = '0;
              state_d = ST_CLR_ROW;
            end else if (char_data_i == CH_CR) begin
              cr_s = 1'b1;
            end else if ((char_data_i == CH_BS) && (cursor_col_o != 6'd0)) begin
              back_s = 1'b1;
              we_d   = 1'b1;
              ad_d   = cur_addr_s - ADDR_W'(1);
              din_d  = {attr_i, CH_SPACE};
            end else begin
              we_d = 1'b0;
            end
          end else begin
            we_d = 1'b0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_CLR_ALL;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE) || clr_wr_d;
  end

  // Controller and write-port registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLR_ALL;
      cnt_q   <= '0;
      attr_q  <= RST_ATTR;
      we_q    <= 1'b0;
      ad_q    <= '0;
      din_q   <= 16'h0000;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      attr_q  <= attr_d;
      we_q    <= we_d;
      ad_q    <= ad_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign vram_we_o  = we_q;
  assign vram_ad_o  = ad_q;
  assign vram_din_o = din_q;

endmodule

// File: tb/tb_vram_console.sv
// Directed bench for vram_console: power-up clear, printing, control codes,
// wrap/row clear, clear_i priority and mid-clear reset.
module tb_vram_console;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        char_valid_i = 1'b0;
  logic [7:0]  char_data_i = 8'h00;
  logic [7:0]  attr_i = 8'h00;
  logic        clear_i = 1'b0;
  logic        char_ready_o;
  logic        busy_o;
  logic        vram_we_o;
  logic [10:0] vram_ad_o;
  logic [15:0] vram_din_o;
  logic [5:0]  cursor_col_o;
  logic [5:0]  cursor_row_o;

  int n_checks = 0;
  int n_errors = 0;

  vram_console dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .char_valid_i (char_valid_i),
    .char_data_i  (char_data_i),
    .attr_i       (attr_i),
    .char_ready_o (char_ready_o),
    .clear_i      (clear_i),
    .busy_o       (busy_o),
    .vram_we_o    (vram_we_o),
    .vram_ad_o    (vram_ad_o),
    .vram_din_o   (vram_din_o),
    .cursor_col_o (cursor_col_o),
    .cursor_row_o (cursor_row_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_we(input string tag, input int bound);
    int n = 0;
    while (vram_we_o !== 1'b1 && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    check_eq(tag, vram_we_o, 1'b1);
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n = 0;
    while (char_ready_o !== 1'b1 && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    check_eq(tag, char_ready_o, 1'b1);
  endtask

  // Caller is at the negedge showing the write to address start.
  task automatic check_full_clear(input string tag, input logic [15:0] exp_din, input int start);
    int bad = 0;
    for (int i = start; i < 2040; i++) begin
      if (i > start) @(negedge clk_i);
      if (vram_we_o !== 1'b1 || vram_ad_o !== 11'(i) || vram_din_o !== exp_din ||
          busy_o !== 1'b1 || char_ready_o !== 1'b0)
        bad++;
    end
    check_eq({tag, "_writes"}, bad, 0);
    @(negedge clk_i);
    check_eq({tag, "_we_after"}, vram_we_o, 1'b0);
    check_eq({tag, "_ready"}, char_ready_o, 1'b1);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_cursor"}, {cursor_row_o, cursor_col_o}, 12'h000);
  endtask

  // Caller is at the negedge just before the first row-clear write.
  task automatic check_row_clear(input string tag, input int base, input logic [15:0] exp_din);
    int bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (vram_we_o !== 1'b1 || vram_ad_o !== 11'(base + i) || vram_din_o !== exp_din ||
          busy_o !== 1'b1 || char_ready_o !== 1'b0)
        bad++;
    end
    check_eq({tag, "_writes"}, bad, 0);
    @(negedge clk_i);
    check_eq({tag, "_we_after"}, vram_we_o, 1'b0);
    check_eq({tag, "_ready"}, char_ready_o, 1'b1);
  endtask

  // Offer one character at a negedge; returns at the negedge after acceptance.
  task automatic send_char(input logic [7:0] ch, input logic [7:0] attr);
    check_eq("send_ready", char_ready_o, 1'b1);
    char_valid_i = 1'b1;
    char_data_i  = ch;
    attr_i       = attr;
    @(negedge clk_i);
    char_valid_i = 1'b0;
  endtask

  initial begin
    int bad;
    logic [7:0] ch;

    repeat (3) @(negedge clk_i);
    check_eq("rst_we", vram_we_o, 1'b0);
    check_eq("rst_ad", vram_ad_o, 11'd0);
    check_eq("rst_din", vram_din_o, 16'h0000);
    check_eq("rst_ready", char_ready_o, 1'b0);
    check_eq("rst_cursor", {cursor_row_o, cursor_col_o}, 12'h000);
    rst_i = 1'b0;
    wait_we("pwr_first_we", 10);
    check_full_clear("pwr_clear", 16'h0F20, 0);

    send_char(8'h41, 8'h1E);
    check_eq("A_we", vram_we_o, 1'b1);
    check_eq("A_ad", vram_ad_o, 11'd0);
    check_eq("A_din", vram_din_o, 16'h1E41);
    check_eq("A_col", cursor_col_o, 6'd1);
    send_char(8'h08, 8'h1E);
    check_eq("bs1_we", vram_we_o, 1'b1);
    check_eq("bs1_ad", vram_ad_o, 11'd0);
    check_eq("bs1_din", vram_din_o, 16'h1E20);
    check_eq("bs1_col", cursor_col_o, 6'd0);
    send_char(8'h08, 8'h1E);
    check_eq("bs2_we", vram_we_o, 1'b0);
    check_eq("bs2_col", cursor_col_o, 6'd0);

    send_char(8'h42, 8'h1E);
    send_char(8'h43, 8'h1E);
    check_eq("C_ad", vram_ad_o, 11'd1);
    check_eq("C_din", vram_din_o, 16'h1E43);
    send_char(8'h01, 8'h1E);
    check_eq("ign_we", vram_we_o, 1'b0);
    check_eq("ign_col", cursor_col_o, 6'd2);
    send_char(8'h0D, 8'h1E);
    check_eq("cr_we", vram_we_o, 1'b0);
    check_eq("cr_cursor", {cursor_row_o, cursor_col_o}, 12'h000);

    bad = 0;
    for (int i = 0; i < 60; i++) begin
      ch = 8'h61 + 8'(i % 26);
      send_char(ch, 8'h1E);
      if (vram_we_o !== 1'b1 || vram_ad_o !== 11'(i) || vram_din_o !== {8'h1E, ch})
        bad++;
    end
    check_eq("line_writes", bad, 0);
    check_eq("line_last_ad", vram_ad_o, 11'd59);
    check_eq("wrap_cursor", {cursor_row_o, cursor_col_o}, {6'd1, 6'd0});
    check_eq("wrap_busy", busy_o, 1'b1);
    check_row_clear("wrap_rowclr", 60, 16'h1E20);

    for (int r = 0; r < 32; r++) begin
      send_char(8'h0A, 8'h1E);
      wait_ready("lf_ready", 100);
    end
    check_eq("row33", {cursor_row_o, cursor_col_o}, {6'd33, 6'd0});
    send_char(8'h0A, 8'h1E);
    check_eq("lfwrap_cursor", {cursor_row_o, cursor_col_o}, 12'h000);
    check_eq("lfwrap_ready", char_ready_o, 1'b0);
    check_row_clear("lfwrap_rowclr", 0, 16'h1E20);

    send_char(8'h0A, 8'h1E);
    for (int i = 0; i < 20; i++) @(negedge clk_i);
    check_eq("mid_row_ad", vram_ad_o, 11'd79);
    clear_i = 1'b1;
    attr_i  = 8'h70;
    @(negedge clk_i);
    clear_i = 1'b0;
    check_eq("clr_we", vram_we_o, 1'b1);
    check_eq("clr_ad", vram_ad_o, 11'd0);
    check_eq("clr_din", vram_din_o, 16'h7020);
    check_full_clear("clr_full", 16'h7020, 0);

    clear_i      = 1'b1;
    char_valid_i = 1'b1;
    char_data_i  = 8'h5A;
    attr_i       = 8'h4F;
    #1;
    check_eq("coinc_ready", char_ready_o, 1'b0);
    @(negedge clk_i);
    clear_i      = 1'b0;
    char_valid_i = 1'b0;
    check_eq("coinc_din", vram_din_o, 16'h4F20);
    check_full_clear("coinc_full", 16'h4F20, 0);

    send_char(8'h0C, 8'h2A);
    check_eq("ff_we", vram_we_o, 1'b1);
    check_eq("ff_ad", vram_ad_o, 11'd0);
    check_eq("ff_din", vram_din_o, 16'h2A20);
    check_eq("ff_busy", busy_o, 1'b1);
    repeat (100) @(negedge clk_i);
    check_eq("ff_mid_ad", vram_ad_o, 11'd100);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("midrst_we", vram_we_o, 1'b0);
    check_eq("midrst_ad", vram_ad_o, 11'd0);
    check_eq("midrst_ready", char_ready_o, 1'b0);
    rst_i = 1'b0;
    wait_we("midrst_first_we", 10);
    check_full_clear("midrst_clear", 16'h0F20, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
